// File: rtl/key_direction_filter_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// key_direction_filter_if : raw key / busy inputs and move-request outputs
// Rev 1.0
// -----------------------------------------------------------------------------
interface key_direction_filter_if;
  logic [3:0] key_n;
  logic       busy;
  logic [3:0] direction;
  logic       dir_valid;
  logic [7:0] press_count;
  logic [1:0] state_dbg;

  // master: the board/controller side that owns the buttons and busy flag
  modport master (
    output key_n,
    output busy,
    input  direction,
    input  dir_valid,
    input  press_count,
    input  state_dbg
  );

  // slave: the filter itself
  modport slave (
    input  key_n,
    input  busy,
    output direction,
    output dir_valid,
    output press_count,
    output state_dbg
  );
endinterface
`default_nettype wire

// File: rtl/key_direction_filter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// key_direction_filter : synchronise, debounce and one-shot four direction keys
// Rev 1.0
// -----------------------------------------------------------------------------
module key_direction_filter #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 8,
  parameter int CNT_W           = 20
) (
  input  logic                   clock,
  input  logic                   reset_n,
  key_direction_filter_if.slave  bus
);

  localparam int               TMR_W    = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    FIRE = 2'b01,
    HOLD = 2'b10,
    LOCK = 2'b11
  } state_t;

  // Synchroniser flops carry the raw active-low level, so reset loads "released".
  logic [3:0] sync1_q;
  logic [3:0] sync2_q;
  logic [3:0] pressed;
  logic [3:0] stable;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
    end else begin
      sync1_q <= bus.key_n;
      sync2_q <= sync1_q;
    end
  end

  assign pressed = ~sync2_q;

  for (genvar k = 0; k < 4; k++) begin : g_key
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    always_comb begin
      cnt_d    = '0;
      stable_d = stable_q;
      if (pressed[k] != stable_q) begin
        if (cnt_q == CNT_LAST) begin
          stable_d = pressed[k];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clock) begin
      if (!reset_n) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable[k] = stable_q;
  end

  logic any_key;
  logic single_key;

  assign any_key    = |stable;
  assign single_key = any_key && ((stable & (stable - 4'd1)) == 4'd0);

  state_t           state_q;
  logic [TMR_W-1:0] timer_q;
  logic [3:0]       dir_q;
  logic             valid_q;
  logic [7:0]       count_q;

  // Outputs are loaded on the edge entering FIRE and cleared on the edge leaving it,
  // so direction is non-zero for exactly PULSE_CYCLES cycles.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_key) begin
            if (single_key && !bus.busy) begin
              state_q <= FIRE;
              dir_q   <= stable;
              valid_q <= 1'b1;
              timer_q <= TMR_LOAD;
              count_q <= count_q + 8'd1;
            end else begin
              state_q <= LOCK;
            end
          end
        end
        FIRE: begin
          if (timer_q == '0) begin
            state_q <= HOLD;
            dir_q   <= '0;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        HOLD, LOCK: begin
          if (!any_key) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          dir_q   <= '0;
        end
      endcase
    end
  end

  assign bus.direction   = dir_q;
  assign bus.dir_valid   = valid_q;
  assign bus.press_count = count_q;
  assign bus.state_dbg   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_key_direction_filter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_key_direction_filter : directed scoreboard bench for key_direction_filter
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_key_direction_filter;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  key_direction_filter_if kif();

  key_direction_filter #(
    .DEBOUNCE_CYCLES(4),
    .PULSE_CYCLES   (8),
    .CNT_W          (20)
  ) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (kif)
  );

  typedef struct {
    logic [3:0]  dir;
    logic [7:0]  cnt;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          total   = 0;
  int          bad     = 0;
  int unsigned cyc     = 0;
  int          pulses  = 0;
  int          run     = 0;
  logic [3:0]  prev_dir = 4'd0;
  logic [7:0]  exp_cnt  = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] kn, input logic [3:0] d);
    exp_t e;
    kif.key_n = kn;
    exp_cnt   = exp_cnt + 8'd1;
    e.dir     = d;
    e.cnt     = exp_cnt;
    e.cyc     = cyc;
    sb.push_back(e);
  endtask

  // Output monitor: pops the scoreboard on every dir_valid and measures pulse length.
  always @(negedge clk) begin
    if (!rst_n) begin
      run      = 0;
      prev_dir = 4'd0;
    end else begin
      if (kif.dir_valid) begin
        exp_t e;
        pulses++;
        chk("valid_first_cycle", 32'(prev_dir), 32'd0);
        if (sb.size() == 0) begin
          chk("spurious_pulse", 32'(kif.direction), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("direction", 32'(kif.direction), 32'(e.dir));
          chk("press_count", 32'(kif.press_count), 32'(e.cnt));
          chk("latency_6_7", 32'((cyc - e.cyc) inside {6, 7}), 32'd1);
        end
      end
      if (kif.direction != 4'd0) begin
        run++;
        chk("fire_state", 32'(kif.state_dbg), 32'd1);
      end else if (run != 0) begin
        chk("pulse_len", 32'(run), 32'd8);
        run = 0;
      end
      prev_dir = kif.direction;
    end
  end

  initial begin
    logic       found;
    logic [3:0] dsel;

    rst_n     = 1'b0;
    kif.key_n = 4'hF;
    kif.busy  = 1'b0;
    wait_cyc(3);
    chk("rst_direction", 32'(kif.direction), 32'd0);
    chk("rst_dir_valid", 32'(kif.dir_valid), 32'd0);
    chk("rst_press_count", 32'(kif.press_count), 32'd0);
    chk("rst_state", 32'(kif.state_dbg), 32'd0);
    rst_n = 1'b1;
    wait_cyc(2);

    // single held press: one pulse, no auto-repeat
    press(4'b1110, 4'b0001);
    wait_cyc(40);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_pulses", 32'(pulses), 32'd1);
    chk("t1_count", 32'(kif.press_count), 32'd1);
    chk("t1_hold_state", 32'(kif.state_dbg), 32'd2);
    kif.key_n = 4'hF;
    wait_cyc(12);
    chk("t1_idle", 32'(kif.state_dbg), 32'd0);

    // bouncing right key, then stable
    for (int i = 0; i < 5; i++) begin
      kif.key_n = 4'b1101;
      wait_cyc(2);
      kif.key_n = 4'hF;
      wait_cyc(2);
    end
    chk("t2_no_pulse_bounce", 32'(pulses), 32'd1);
    press(4'b1101, 4'b0010);
    wait_cyc(20);
    chk("t2_sb_empty", 32'(sb.size()), 32'd0);
    chk("t2_pulses", 32'(pulses), 32'd2);
    chk("t2_count", 32'(kif.press_count), 32'd2);
    kif.key_n = 4'hF;
    wait_cyc(12);

    // chord: left + down together
    kif.key_n = 4'b1010;
    wait_cyc(20);
    chk("t3_lock", 32'(kif.state_dbg), 32'd3);
    chk("t3_dir_zero", 32'(kif.direction), 32'd0);
    chk("t3_count", 32'(kif.press_count), 32'd2);
    kif.key_n = 4'b1110;
    wait_cyc(12);
    chk("t3_lock_partial", 32'(kif.state_dbg), 32'd3);
    kif.key_n = 4'hF;
    wait_cyc(12);
    chk("t3_idle", 32'(kif.state_dbg), 32'd0);
    chk("t3_pulses", 32'(pulses), 32'd2);

    // press while busy, busy drops mid-hold
    kif.busy  = 1'b1;
    kif.key_n = 4'b0111;
    wait_cyc(15);
    kif.busy = 1'b0;
    wait_cyc(15);
    chk("t4_lock", 32'(kif.state_dbg), 32'd3);
    chk("t4_pulses", 32'(pulses), 32'd2);
    chk("t4_count", 32'(kif.press_count), 32'd2);
    kif.key_n = 4'hF;
    wait_cyc(12);
    press(4'b0111, 4'b1000);
    wait_cyc(20);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);
    chk("t4_pulses_after", 32'(pulses), 32'd3);
    kif.key_n = 4'hF;
    wait_cyc(12);

    // reset during the third FIRE cycle
    press(4'b1110, 4'b0001);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (kif.dir_valid) found = 1'b1;
    end
    chk("t5_pulse_seen", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_dir_zero", 32'(kif.direction), 32'd0);
    chk("t5_count_zero", 32'(kif.press_count), 32'd0);
    chk("t5_state_idle", 32'(kif.state_dbg), 32'd0);
    rst_n     = 1'b1;
    kif.key_n = 4'hF;
    exp_cnt   = 8'd0;
    wait_cyc(12);
    chk("t5_pulses", 32'(pulses), 32'd4);

    // 256 clean presses wrap the counter
    for (int i = 0; i < 256; i++) begin
      dsel = 4'b0001 << (i % 4);
      press(~dsel, dsel);
      wait_cyc(16);
      kif.key_n = 4'hF;
      wait_cyc(10);
    end
    chk("t6_count_wrap", 32'(kif.press_count), 32'd0);
    chk("t6_sb_empty", 32'(sb.size()), 32'd0);
    chk("t6_pulses", 32'(pulses), 32'd260);
    chk("t6_idle", 32'(kif.state_dbg), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
